// File: rtl/build_info_pkg.sv
// Shared state encoding, frame geometry and ASCII helper for build_info_streamer.
package build_info_pkg;

  typedef logic [2:0] bis_state_t;

  localparam bis_state_t S_IDLE = 3'd0;
  localparam bis_state_t S_SCAN = 3'd1;
  localparam bis_state_t S_HDR  = 3'd2;
  localparam bis_state_t S_IDX  = 3'd3;
  localparam bis_state_t S_HASH = 3'd4;
  localparam bis_state_t S_TS   = 3'd5;
  localparam bis_state_t S_TRL  = 3'd6;
  localparam bis_state_t S_DONE = 3'd7;

  localparam int BYTES_HASH        = 8;
  localparam int BYTES_TS          = 4;
  localparam int BIN_BYTES_PER_SRC = 14;
  localparam int ASC_CHARS_PER_SRC = 27;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/build_info_streamer_bis_byte_mux.sv
// Combinational pick of the next stream byte from the snapshot.
// BUILD_INFO_ASCII_EN switches idx/hash/ts bytes to two ASCII hex chars.
module bis_byte_mux
  import build_info_pkg::*;
#(
  parameter int          N_SRC    = 3,
  parameter int          IW       = 2,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  TRL_BYTE = 8'h0A
) (
  input  bis_state_t             state,
  input  logic [IW-1:0]          src_idx,
  input  logic [2:0]             byte_cnt,
`ifdef BUILD_INFO_ASCII_EN
  input  logic                   nib_hi,
`endif
  input  logic [N_SRC*64-1:0]    hash_snap,
  input  logic [N_SRC*32-1:0]    ts_snap,
  output logic [7:0]             cur_byte
);

  logic [63:0] hash_sel;
  logic [31:0] ts_sel;
  logic [7:0]  hash_b;
  logic [7:0]  ts_b;
  logic [7:0]  raw;

  always_comb begin
    hash_sel = '0;
    ts_sel   = '0;
    hash_b   = '0;
    ts_b     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (src_idx == IW'(k)) begin
        hash_sel = hash_snap[k*64 +: 64];
        ts_sel   = ts_snap[k*32 +: 32];
      end
    end
    for (int b = 0; b < BYTES_HASH; b++)
      if (byte_cnt == 3'(b)) hash_b = hash_sel[b*8 +: 8];
    for (int b = 0; b < BYTES_TS; b++)
      if (byte_cnt == 3'(b)) ts_b = ts_sel[b*8 +: 8];
  end

  always_comb begin
    raw = '0;
    case (state)
      S_IDX:   raw = 8'(src_idx);
      S_HASH:  raw = hash_b;
      S_TS:    raw = ts_b;
      default: raw = '0;
    endcase
  end

  always_comb begin
    cur_byte = '0;
    case (state)
`ifdef BUILD_INFO_ASCII_EN
      S_HDR:               cur_byte = 8'h23;
      S_IDX, S_HASH, S_TS: cur_byte = hex_char(nib_hi ? raw[7:4] : raw[3:0]);
`else
      S_HDR:               cur_byte = HDR_BYTE;
      S_IDX, S_HASH, S_TS: cur_byte = raw;
`endif
      S_TRL:               cur_byte = TRL_BYTE;
      default:             cur_byte = '0;
    endcase
  end

endmodule

// File: rtl/build_info_streamer.sv
// Frames snapshotted build-ID words into a valid/ready byte stream.
// BUILD_INFO_ASCII_EN selects the ASCII-hex frame variant.
//
// state  | meaning
// IDLE   | waiting for start_i
// SCAN   | testing mask bit of src_idx, one source per cycle
// HDR    | header byte
// IDX    | source index byte
// HASH   | hash bytes, byte_cnt 7..0
// TS     | timestamp bytes, byte_cnt 3..0
// TRL    | trailer byte
// DONE   | one-cycle done pulse
module build_info_streamer
  import build_info_pkg::*;
#(
  parameter int          N_SRC    = 3,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  TRL_BYTE = 8'h0A
) (
  input  logic                   clk100,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [N_SRC-1:0]       src_mask_i,
  input  logic [N_SRC*64-1:0]    hash_i,
  input  logic [N_SRC*32-1:0]    ts_i,
  output logic [7:0]             tdata_o,
  output logic                   tvalid_o,
  input  logic                   tready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int IW = $clog2(N_SRC + 1);

  bis_state_t            state, nxt_state;
  logic [IW-1:0]         src_idx, nxt_idx;
  logic [2:0]            byte_cnt, nxt_cnt;
  logic [N_SRC-1:0]      mask_snap;
  logic [N_SRC*64-1:0]   hash_snap;
  logic [N_SRC*32-1:0]   ts_snap;
  logic                  xfer, last_src, mask_bit, byte_last, emit;
  logic [7:0]            nxt_byte;
`ifdef BUILD_INFO_ASCII_EN
  logic                  nib_hi, nxt_nib;
  assign byte_last = ~nib_hi;
`else
  assign byte_last = 1'b1;
`endif

  assign xfer     = tvalid_o & tready_i;
  assign last_src = (src_idx == IW'(N_SRC - 1));

  always_comb begin
    mask_bit = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      if (src_idx == IW'(k)) mask_bit = mask_snap[k];
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = src_idx;
    nxt_cnt   = byte_cnt;
`ifdef BUILD_INFO_ASCII_EN
    nxt_nib   = nib_hi;
    if (xfer && (state == S_HDR)) nxt_nib = 1'b1;
    if (xfer && (state == S_IDX || state == S_HASH || state == S_TS)) nxt_nib = ~nib_hi;
`endif
    case (state)
      S_IDLE: if (start_i) begin
        nxt_state = S_SCAN;
        nxt_idx   = '0;
        nxt_cnt   = '0;
      end
      S_SCAN: begin
        if (mask_bit) nxt_state = S_HDR;
        else begin
          nxt_idx = src_idx + IW'(1);
          if (last_src) nxt_state = S_TRL;
        end
      end
      S_HDR: if (xfer) nxt_state = S_IDX;
      S_IDX: if (xfer && byte_last) begin
        nxt_state = S_HASH;
        nxt_cnt   = 3'(BYTES_HASH - 1);
      end
      S_HASH: if (xfer && byte_last) begin
        if (byte_cnt == 3'd0) begin
          nxt_state = S_TS;
          nxt_cnt   = 3'(BYTES_TS - 1);
        end else nxt_cnt = byte_cnt - 3'd1;
      end
      S_TS: if (xfer && byte_last) begin
        if (byte_cnt == 3'd0) begin
          nxt_idx   = src_idx + IW'(1);
          nxt_state = last_src ? S_TRL : S_SCAN;
        end else nxt_cnt = byte_cnt - 3'd1;
      end
      S_TRL:   if (xfer) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Mux looks at next-cycle selectors so tdata_o can be a plain register.
  bis_byte_mux #(
    .N_SRC    (N_SRC),
    .IW       (IW),
    .HDR_BYTE (HDR_BYTE),
    .TRL_BYTE (TRL_BYTE)
  ) u_mux (
    .state     (nxt_state),
    .src_idx   (nxt_idx),
    .byte_cnt  (nxt_cnt),
`ifdef BUILD_INFO_ASCII_EN
    .nib_hi    (nxt_nib),
`endif
    .hash_snap (hash_snap),
    .ts_snap   (ts_snap),
    .cur_byte  (nxt_byte)
  );

  assign emit = (nxt_state == S_HDR) || (nxt_state == S_IDX) || (nxt_state == S_HASH) ||
                (nxt_state == S_TS)  || (nxt_state == S_TRL);

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src_idx   <= '0;
      byte_cnt  <= '0;
      mask_snap <= '0;
      hash_snap <= '0;
      ts_snap   <= '0;
      tdata_o   <= '0;
      tvalid_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef BUILD_INFO_ASCII_EN
      nib_hi    <= 1'b1;
`endif
    end else begin
      state    <= nxt_state;
      src_idx  <= nxt_idx;
      byte_cnt <= nxt_cnt;
`ifdef BUILD_INFO_ASCII_EN
      nib_hi   <= nxt_nib;
`endif
      if (state == S_IDLE && start_i) begin
        mask_snap <= src_mask_i;
        hash_snap <= hash_i;
        ts_snap   <= ts_i;
      end
      tvalid_o <= emit;
      tdata_o  <= emit ? nxt_byte : 8'h00;
      busy_o   <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      done_o   <= (nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_build_info_streamer.sv
// Directed bench for build_info_streamer (binary build, or ASCII build when
// BUILD_INFO_ASCII_EN is defined).
module tb_build_info_streamer;
  import build_info_pkg::*;

  localparam int N = 3;

  logic              clk100 = 1'b0;
  logic              rst;
  logic              start_i;
  logic [N-1:0]      src_mask_i;
  logic [N*64-1:0]   hash_i;
  logic [N*32-1:0]   ts_i;
  logic [7:0]        tdata_o;
  logic              tvalid_o;
  logic              tready_i;
  logic              busy_o;
  logic              done_o;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  logic [N*64-1:0] hash_v;
  logic [N*32-1:0] ts_v;

  always #5 clk100 = ~clk100;

  build_info_streamer #(.N_SRC(N), .HDR_BYTE(8'hA5), .TRL_BYTE(8'h0A)) dut (
    .clk100     (clk100),
    .rst        (rst),
    .start_i    (start_i),
    .src_mask_i (src_mask_i),
    .hash_i     (hash_i),
    .ts_i       (ts_i),
    .tdata_o    (tdata_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_val(input logic [7:0] b);
    string hx;
    hx = "0123456789ABCDEF";
`ifdef BUILD_INFO_ASCII_EN
    exp_q.push_back(8'(hx[b[7:4]]));
    exp_q.push_back(8'(hx[b[3:0]]));
`else
    exp_q.push_back(b);
`endif
  endtask

  // Expected frame built straight from the frame description.
  task automatic build_exp(input logic [N-1:0] mask, input logic [N*64-1:0] h,
                           input logic [N*32-1:0] t);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
`ifdef BUILD_INFO_ASCII_EN
        exp_q.push_back(8'h23);
`else
        exp_q.push_back(8'hA5);
`endif
        push_val(8'(k));
        for (int b = 7; b >= 0; b--) push_val(h[k*64 + b*8 +: 8]);
        for (int b = 3; b >= 0; b--) push_val(t[k*32 + b*8 +: 8]);
      end
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic cmp_frame(input string tag);
    int m;
    chk({tag, "_len"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_byte"}, got[i], exp_q[i]);
  endtask

  // Cycle 0 is the cycle start_i is sampled; returns when done_o has been seen.
  task automatic run_frame(input logic [N-1:0] mask, input bit rnd,
                           output int first_valid, output int done_cyc, output int trl_cyc);
    int   cyc;
    bit   stall;
    logic [7:0] held;
    got.delete();
    first_valid = -1; done_cyc = -1; trl_cyc = -1; stall = 0; held = '0;
    @(negedge clk100);
    src_mask_i = mask; start_i = 1'b1; tready_i = 1'b1;
    @(negedge clk100);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 400 && done_cyc < 0) begin
      if (stall) begin
        chk("hold_valid", tvalid_o, 1'b1);
        chk("hold_data", tdata_o, held);
      end
      if (tvalid_o && first_valid < 0) first_valid = cyc;
      if (done_o) begin
        done_cyc = cyc;
        chk("busy_in_done", busy_o, 1'b0);
      end
      tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = tvalid_o && !tready_i;
      held  = tdata_o;
      if (tvalid_o && tready_i) begin
        got.push_back(tdata_o);
        trl_cyc = cyc;
      end
      @(negedge clk100);
      cyc++;
    end
    tready_i = 1'b1;
    chk("frame_done_seen", done_cyc >= 0, 1'b1);
    chk("done_after_trl", done_cyc, trl_cyc + 1);
    chk("done_one_cycle", done_o, 1'b0);
  endtask

  int fv, dc, tc, n, cyc;
  bit stray;

  initial begin
    logic [7:0] hand_bin[16] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                                 8'hCD, 8'hEF, 8'h65, 8'hA1, 8'hB2, 8'hC3, 8'hA5, 8'h01};
    string hand_asc;
    hand_asc = "#000123456789ABCDEF65A1B2C3";
    hash_v = {64'hDEADBEEFCAFEF00D, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    ts_v   = {32'h0BADF00D, 32'h11223344, 32'h65A1B2C3};
    rst = 1'b1; start_i = 1'b0; tready_i = 1'b1; src_mask_i = '0;
    hash_i = hash_v; ts_i = ts_v;
    repeat (2) @(negedge clk100);
    chk("rst_tdata", tdata_o, 8'h00);
    chk("rst_tvalid", tvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst = 1'b0;

`ifdef BUILD_INFO_ASCII_EN
    build_exp(3'b001, hash_v, ts_v);
    run_frame(3'b001, 1'b0, fv, dc, tc);
    chk("asc_first_valid", fv, 2);
    chk("asc_len", got.size(), ASC_CHARS_PER_SRC + 1);
    for (int i = 0; i < ASC_CHARS_PER_SRC; i++)
      if (i < got.size()) chk("asc_hand", got[i], 8'(hand_asc[i]));
    if (got.size() > 0) chk("asc_trl", got[got.size()-1], 8'h0A);
    cmp_frame("asc_model");
`else
    build_exp(3'b111, hash_v, ts_v);
    run_frame(3'b111, 1'b0, fv, dc, tc);
    chk("all_first_valid", fv, 2);
    chk("all_len", got.size(), 3 * BIN_BYTES_PER_SRC + 1);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) chk("all_hand", got[i], hand_bin[i]);
    if (got.size() > 0) chk("all_trl", got[got.size()-1], 8'h0A);
    cmp_frame("all_model");

    run_frame(3'b100, 1'b0, fv, dc, tc);
    chk("m100_first_valid", fv, 4);
    chk("m100_len", got.size(), 15);
    if (got.size() > 1) begin
      chk("m100_hdr", got[0], 8'hA5);
      chk("m100_idx", got[1], 8'h02);
    end

    run_frame(3'b000, 1'b0, fv, dc, tc);
    chk("m000_first_valid", fv, 4);
    chk("m000_len", got.size(), 1);
    if (got.size() > 0) chk("m000_trl", got[0], 8'h0A);
    chk("m000_done_cyc", dc, 5);
`endif

    // Random backpressure: same bytes as the unstalled run.
    build_exp(3'b111, hash_v, ts_v);
    run_frame(3'b111, 1'b1, fv, dc, tc);
    cmp_frame("rnd_ready");

    // Restarts and input changes while busy must not disturb the frame.
    build_exp(3'b011, hash_v, ts_v);
    fork
      run_frame(3'b011, 1'b0, fv, dc, tc);
      begin
        repeat (4) @(negedge clk100);
        hash_i = ~hash_v; ts_i = ~ts_v; src_mask_i = 3'b100; start_i = 1'b1;
        repeat (6) @(negedge clk100);
        start_i = 1'b0;
      end
    join
    cmp_frame("snapshot");
    hash_i = hash_v; ts_i = ts_v;
    stray = 0;
    repeat (10) begin
      @(negedge clk100);
      if (tvalid_o || busy_o) stray = 1;
    end
    chk("no_requeue", stray, 1'b0);

    // start_i during DONE is dropped.
    fork
      run_frame(3'b000, 1'b0, fv, dc, tc);
      begin
        repeat (6) @(negedge clk100);
        start_i = 1'b1;
        @(negedge clk100);
        start_i = 1'b0;
      end
    join
    stray = 0;
    repeat (10) begin
      @(negedge clk100);
      if (tvalid_o || busy_o) stray = 1;
    end
    chk("start_in_done_ignored", stray, 1'b0);

    // Reset after the 5th byte, then a clean frame.
    @(negedge clk100);
    src_mask_i = 3'b111; start_i = 1'b1; tready_i = 1'b1;
    @(negedge clk100);
    start_i = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      if (tvalid_o) n++;
      if (n < 5) begin
        @(negedge clk100);
        cyc++;
      end
    end
    chk("rst_reach5", n, 5);
    @(posedge clk100);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tdata", tdata_o, 8'h00);
    chk("midrst_tvalid", tvalid_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    @(negedge clk100);
    rst = 1'b0;
    build_exp(3'b111, hash_v, ts_v);
    run_frame(3'b111, 1'b0, fv, dc, tc);
    chk("post_rst_first_valid", fv, 2);
    cmp_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
